// File: rtl/coin_detector.sv
// -----------------------------------------------------------------------------
// coin_detector
//
// Front end for the vending-machine FSM. It synchronises and debounces the two
// raw coin-chute sensors and rejects events where both sensors are active.
// It produces one clean event per physical coin.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-low reset
//   sense_5     : raw 5-unit chute sensor (asynchronous, high = coin present)
//   sense_10    : raw 10-unit chute sensor (asynchronous, high = coin present)
//   coin_code   : 01 = 5 units, 10 = 10 units; 00 whenever coin_valid = 0
//   coin_valid  : one-cycle strobe for an accepted coin
//   coin_reject : one-cycle strobe for an ambiguous event (both sensors active)
//   busy        : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module coin_detector #(
  parameter int DEBOUNCE_CYCLES = 4,   // 2..255
  parameter int GAP_CYCLES      = 8    // 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_5,
  input  logic       sense_10,
  output logic [1:0] coin_code,
  output logic       coin_valid,
  output logic       coin_reject,
  output logic       busy
);

  localparam int MAX_CNT = (DEBOUNCE_CYCLES > GAP_CYCLES) ? DEBOUNCE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] DEB_FULL = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With no lockout this value is never used, so clamp it to keep the cast legal.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  localparam logic [1:0] CODE_5  = 2'b01;
  localparam logic [1:0] CODE_10 = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    REJECT,
    RELEASE,
    LOCKOUT
  } state_t;

  // Two-flop synchronisers
  logic s5_meta_q, s5_q;
  logic s10_meta_q, s10_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s5_meta_q  <= 1'b0;
      s5_q       <= 1'b0;
      s10_meta_q <= 1'b0;
      s10_q      <= 1'b0;
    end else begin
      s5_meta_q  <= sense_5;
      s5_q       <= s5_meta_q;
      s10_meta_q <= sense_10;
      s10_q      <= s10_meta_q;
    end
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cand_q;
  logic [1:0]       coin_code_q;
  logic             coin_valid_q;
  logic             coin_reject_q;
  logic             busy_q;

  // Candidate sensor and the opposite sensor, as seen from the latched candidate
  logic cand_hi;
  logic other_hi;

  always_comb begin
    cand_hi  = (cand_q == CODE_5) ? s5_q  : s10_q;
    other_hi = (cand_q == CODE_5) ? s10_q : s5_q;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Outputs are registered. Each strobe is set on the transition into the
  // state it belongs to, so the strobe is aligned with that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= 2'b00;
      coin_code_q   <= 2'b00;
      coin_valid_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      coin_code_q   <= 2'b00;
      coin_valid_q  <= 1'b0;
      coin_reject_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (s5_q && s10_q) begin
            state_q       <= REJECT;
            coin_reject_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (s5_q || s10_q) begin
            cand_q  <= s5_q ? CODE_5 : CODE_10;
            cnt_q   <= CNT_W'(1);
            state_q <= DEBOUNCE;
            busy_q  <= 1'b1;
          end
        end

        DEBOUNCE: begin
          // An ambiguous event takes priority over the glitch filter.
          if (other_hi) begin
            state_q       <= REJECT;
            coin_reject_q <= 1'b1;
          end else if (!cand_hi) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_FULL) begin
            state_q      <= EMIT;
            coin_valid_q <= 1'b1;
            coin_code_q  <= cand_q;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        EMIT, REJECT: begin
          state_q <= RELEASE;
          cnt_q   <= '0;
        end

        RELEASE: begin
          // cnt_q counts consecutive all-low samples. Any high sample restarts it,
          // so a coin parked in the chute holds this state.
          if (s5_q || s10_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= LOCKOUT;
            end
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        LOCKOUT: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign coin_code   = coin_code_q;
  assign coin_valid  = coin_valid_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_coin_detector.sv
// -----------------------------------------------------------------------------
// tb_coin_detector
//
// Testbench for coin_detector with DEBOUNCE_CYCLES = 4 and GAP_CYCLES = 8.
// The scenario tasks push the events they expect into a queue. A negedge
// monitor pops the queue each time the DUT produces a coin or reject strobe.
// Event encoding: {reject, code}. 3'b001 = 5-unit coin, 3'b010 = 10-unit coin,
// 3'b100 = reject.
// -----------------------------------------------------------------------------
module tb_coin_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_5;
  logic       sense_10;
  logic [1:0] coin_code;
  logic       coin_valid;
  logic       coin_reject;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  localparam logic [2:0] EV_5   = 3'b001;
  localparam logic [2:0] EV_10  = 3'b010;
  localparam logic [2:0] EV_REJ = 3'b100;

  coin_detector #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sense_5    (sense_5),
    .sense_10   (sense_10),
    .coin_code  (coin_code),
    .coin_valid (coin_valid),
    .coin_reject(coin_reject),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: runs only while reset is released.
  always @(negedge clk) begin
    logic [2:0] obs;
    logic [2:0] exp;
    if (rst) begin
      checks++;
      if (coin_valid && coin_reject) begin
        failures++;
        $display("FAIL exclusivity: coin_valid=%0b coin_reject=%0b, required not both high",
                 coin_valid, coin_reject);
      end
      checks++;
      if (!coin_valid && coin_code !== 2'b00) begin
        failures++;
        $display("FAIL code_idle: coin_code=%b while coin_valid=0, required 00", coin_code);
      end
      if (coin_valid || coin_reject) begin
        obs = {coin_reject, coin_code};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got event %b at %0t, required none", obs, $time);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            failures++;
            $display("FAIL event: got %b at %0t, required %b", obs, $time, exp);
          end else begin
            $display("event %b at %0t matches", obs, $time);
          end
        end
      end
    end
  end

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every pushed event should have been consumed by the time a scenario ends.
  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing: %0d expected events not produced, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b, required 0", name, busy);
    end
    $display("scenario %s done", name);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    sense_5  = 1'b0;
    sense_10 = 1'b0;
    tick(3);
    checks++;
    if ({coin_code, coin_valid, coin_reject, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: code=%b valid=%b reject=%b busy=%b, required all 0",
               coin_code, coin_valid, coin_reject, busy);
    end
    rst = 1'b1;
    tick(5);
    checks++;
    if ({coin_code, coin_valid, coin_reject, busy} !== 5'b0) begin
      failures++;
      $display("FAIL post_reset_outputs: code=%b valid=%b reject=%b busy=%b, required all 0",
               coin_code, coin_valid, coin_reject, busy);
    end
    $display("scenario reset done");
  endtask

  // sense_5 is high at edges 0..19. The valid strobe is expected just after
  // edge 6. busy rises after edge 2. s5 goes low after edge 21, RELEASE
  // completes at edge 25 and LOCKOUT ends at edge 33.
  task automatic test_single_5();
    exp_q.push_back(EV_5);
    sense_5 = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (coin_valid !== (e == 6)) begin
        failures++;
        $display("FAIL single5_valid_edge%0d: coin_valid=%b, required %b", e, coin_valid, (e == 6));
      end
      checks++;
      if (busy !== (e >= 2 && e < 33)) begin
        failures++;
        $display("FAIL single5_busy_edge%0d: busy=%b, required %b", e, busy, (e >= 2 && e < 33));
      end
      if (e == 19) sense_5 = 1'b0;
    end
    check_drained("single_5");
  endtask

  task automatic test_glitch_10();
    sense_10 = 1'b1;
    tick(3);
    sense_10 = 1'b0;
    tick(12);
    check_drained("glitch_10");
  endtask

  task automatic test_reject();
    exp_q.push_back(EV_REJ);
    sense_5 = 1'b1;
    tick(2);
    sense_10 = 1'b1;
    tick(10);
    sense_5  = 1'b0;
    sense_10 = 1'b0;
    tick(40);
    check_drained("reject");
  endtask

  task automatic test_back_to_back(input int gap, input int n_expected, input string name);
    for (int i = 0; i < n_expected; i++) exp_q.push_back(EV_10);
    sense_10 = 1'b1;
    tick(10);
    sense_10 = 1'b0;
    tick(gap);
    sense_10 = 1'b1;
    tick(10);
    sense_10 = 1'b0;
    tick(40);
    check_drained(name);
  endtask

  task automatic test_bounce_10();
    exp_q.push_back(EV_10);
    for (int i = 0; i < 6; i++) begin
      sense_10 = (i % 2 == 0);
      tick(1);
    end
    sense_10 = 1'b1;
    tick(15);
    sense_10 = 1'b0;
    tick(40);
    check_drained("bounce_10");
  endtask

  task automatic test_reset_mid();
    sense_5 = 1'b1;
    tick(4);              // DEBOUNCE was entered at edge 2
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({coin_code, coin_valid, coin_reject, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_async: code=%b valid=%b reject=%b busy=%b, required all 0",
               coin_code, coin_valid, coin_reject, busy);
    end
    tick(3);
    checks++;
    if ({coin_code, coin_valid, coin_reject, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_held: code=%b valid=%b reject=%b busy=%b, required all 0",
               coin_code, coin_valid, coin_reject, busy);
    end
    // Release reset between edges. The next rising edge counts as edge 0.
    rst = 1'b1;
    exp_q.push_back(EV_5);
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (coin_valid !== (e == 6)) begin
        failures++;
        $display("FAIL reset_mid_valid_edge%0d: coin_valid=%b, required %b", e, coin_valid, (e == 6));
      end
    end
    sense_5 = 1'b0;
    tick(40);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_5();
    test_glitch_10();
    test_reject();
    test_back_to_back(3, 1, "b2b_gap3");
    test_back_to_back(20, 2, "b2b_gap20");
    test_bounce_10();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_detector.md
Name: coin_detector

Overview:
- Front-end stage directly upstream of the vending-machine FSM.
- Synchronizes and debounces the two raw coin-chute sensors (5-unit and 10-unit), rejects ambiguous events, and emits one clean coin event per physical coin.
- coin_code connects to the FSM's 2-bit coin input: 01 = 5 units, 10 = 10 units, 00 = no coin.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a level must hold to be accepted; legal range 2..255.
- GAP_CYCLES, 8, lockout cycles after a coin clears the chute, during which sensors are ignored; legal range 0..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset; low clears all state immediately.
- sense_5  input  1  raw 5-unit chute sensor; asynchronous; high = coin present.
- sense_10  input  1  raw 10-unit chute sensor; asynchronous; high = coin present.
- coin_code  output  2  01 = 5, 10 = 10; nonzero only while coin_valid = 1, else 00.
- coin_valid  output  1  one-cycle strobe for an accepted coin.
- coin_reject  output  1  one-cycle strobe for an ambiguous event (both sensors active).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, counter = 0, synchronizer flops = 0; coin_code = 00, coin_valid = 0, coin_reject = 0, busy = 0. All outputs are registered.
- Synchronizer: 2-flop synchronizer per sensor, giving s5 and s10. The FSM uses only s5 and s10.
- Counter: a single counter, sized to hold max(DEBOUNCE_CYCLES, GAP_CYCLES). It saturates and never wraps.
- IDLE:
  - Exactly one of s5/s10 high: latch that sensor as the candidate, counter = 1, go to DEBOUNCE.
  - Both high: go to REJECT.
  - Neither high: stay in IDLE.
- DEBOUNCE:
  - Other sensor goes high: go to REJECT.
  - Candidate drops low: go to IDLE silently, with no strobe (glitch filter).
  - Counter == DEBOUNCE_CYCLES with the candidate still high: go to EMIT.
  - Otherwise: counter + 1.
- EMIT (1 cycle): coin_valid = 1, coin_code = candidate code. Next state is RELEASE with counter = 0.
- REJECT (1 cycle): coin_reject = 1, coin_code = 00. Next state is RELEASE with counter = 0.
- RELEASE:
  - Waits until s5 = s10 = 0 for DEBOUNCE_CYCLES consecutive cycles.
  - Any high sample resets the counter to 0.
  - When the low-time is satisfied: go to LOCKOUT (counter = 0), or to IDLE if GAP_CYCLES = 0.
  - A coin that stays in the chute indefinitely holds RELEASE; no second event is produced.
- LOCKOUT:
  - Counts GAP_CYCLES cycles, ignoring sensors, then goes to IDLE.
  - A sensor already high at the end of lockout is treated as a new coin from IDLE.
- Latency: raw sensor stable high before edge 0 gives s high after edge 1, and IDLE samples it at edge 2. coin_valid is high from just after edge DEBOUNCE_CYCLES+2 until just after edge DEBOUNCE_CYCLES+3.
- Minimum coin-to-coin spacing: one coin per full DEBOUNCE + EMIT + RELEASE + LOCKOUT sequence. Inputs arriving earlier are ignored, not queued.
- Output exclusivity: coin_valid and coin_reject are never high in the same cycle. coin_code = 00 whenever coin_valid = 0.
- Reset asserted mid-sequence (any state): the in-progress coin is discarded with no strobe. After release of reset the FSM starts in IDLE; a sensor still high is treated as a new coin.

Test Plan:
- Reset release, then sense_5 held high 20 cycles (DEBOUNCE_CYCLES = 4, GAP_CYCLES = 8) -> single cycle with coin_valid = 1 and coin_code = 01, starting after edge 6; busy high from after edge 2 until the lockout completes.
- sense_10 pulse 3 synchronized cycles long, then low -> no coin_valid, no coin_reject; FSM returns to IDLE and busy falls.
- sense_5 high, then sense_10 also rises after 2 cycles, both held 10 cycles -> one coin_reject pulse, coin_code = 00, no coin_valid.
- Two sense_10 coins, each 10 cycles high, separated by 3 low cycles -> exactly one event. Repeat with 20-cycle separation -> two coin_valid strobes, each coin_code = 10.
- sense_10 bouncing (1-cycle lows) for 6 cycles, then stable high -> exactly one coin_valid, coin_code = 10.
- rst driven low while in DEBOUNCE, then released with sense_5 still high -> outputs 0 immediately while reset is low; after release, one coin_valid with coin_code = 01, after the full latency counted from the release.
